// File: rtl/mrb_pkg.sv
// Shared types and sizing helpers for the multi-row line buffer.
package mrb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    FLUSH,
    DONE
  } state_t;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/line_mem.sv
// One image line of pixel storage: combinational read of the old word, write on the clock edge,
// so a read and a write to the same address in one cycle returns the previous contents.
module line_mem
  import mrb_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int WIDTH  = 17,
  parameter int ADDR_W = clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [WIDTH];

  assign rd_data = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wr_data;
  end

endmodule

// File: rtl/multi_row_buffer.sv
// ROWS vertically aligned taps over a raster stream, with vertical-fill tracking,
// a self-timed padded flush after done_i, and sticky overrun detection.
//
// state | meaning
// IDLE  | waiting for the first pixel of a frame
// FILL  | accepting pixels, one push per valid_i
// FLUSH | pushing PAD_VAL every cycle for FLUSH_LINES lines; valid_i is an overrun
// DONE  | frame finished; col/line_cnt are cleared, done_o follows one cycle later
module multi_row_buffer
  import mrb_pkg::*;
#(
  parameter int                DATA_W      = 8,
  parameter int                ROWS        = 5,
  parameter int                WIDTH       = 17,
  parameter int                FLUSH_LINES = 2,
  parameter logic [DATA_W-1:0] PAD_VAL     = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_i,
  input  logic [DATA_W-1:0]      data_i,
  input  logic                   done_i,
  output logic [ROWS*DATA_W-1:0] rows_o,
  output logic                   valid_o,
  output logic                   win_valid_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   overrun_o
);

  localparam int CW = clog2(WIDTH);
  localparam int LW = clog2(ROWS);
  localparam int FW = clog2(FLUSH_LINES * WIDTH + 1);
  localparam logic [CW-1:0] COL_LAST   = CW'(WIDTH - 1);
  localparam logic [LW-1:0] LINE_FULL  = LW'(ROWS - 1);
  localparam logic [FW-1:0] FLUSH_LOAD = FW'((FLUSH_LINES > 0) ? FLUSH_LINES * WIDTH - 1 : 0);

  state_t            state, state_next;
  logic [CW-1:0]     col;
  logic [LW-1:0]     line_cnt;
  logic [FW-1:0]     flush_cnt;
  logic              push;
  logic [DATA_W-1:0] push_data;
  logic [DATA_W-1:0] rd_data [ROWS-1];
  logic [DATA_W-1:0] wr_data [ROWS-1];

  assign push_data = (state == FLUSH) ? PAD_VAL : data_i;

  // Each push shifts the column down one line: mem0 takes the new pixel, mem k takes mem k-1's old word.
  for (genvar k = 0; k < ROWS - 1; k++) begin : g_mem
    if (k == 0) begin : g_first
      assign wr_data[k] = push_data;
    end else begin : g_next
      assign wr_data[k] = rd_data[k-1];
    end

    line_mem #(
      .DATA_W (DATA_W),
      .WIDTH  (WIDTH),
      .ADDR_W (CW)
    ) u_line_mem (
      .clk     (clk),
      .we      (push),
      .addr    (col),
      .wr_data (wr_data[k]),
      .rd_data (rd_data[k])
    );
  end

  always_comb begin
    state_next = state;
    push       = 1'b0;
    case (state)
      IDLE: begin
        if (valid_i) begin
          push       = 1'b1;
          state_next = FILL;
        end
      end
      FILL: begin
        push = valid_i;
        if (done_i) state_next = (FLUSH_LINES == 0) ? DONE : FLUSH;
      end
      FLUSH: begin
        push = 1'b1;
        if (flush_cnt == '0) state_next = DONE;
      end
      DONE: begin
        // A pixel arriving here opens the next frame at column 0.
        push       = valid_i;
        state_next = valid_i ? FILL : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      col       <= '0;
      line_cnt  <= '0;
      flush_cnt <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      state  <= state_next;
      busy_o <= (state_next != IDLE);
      done_o <= (state == DONE);
      if (state == FLUSH && valid_i) overrun_o <= 1'b1;

      if (state_next == DONE) begin
        col      <= '0;
        line_cnt <= '0;
      end else if (push) begin
        if (col == COL_LAST) begin
          col <= '0;
          if (line_cnt != LINE_FULL) line_cnt <= line_cnt + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end

      if (state == FILL && state_next == FLUSH) flush_cnt <= FLUSH_LOAD;
      else if (state == FLUSH && flush_cnt != '0) flush_cnt <= flush_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rows_o      <= '0;
      valid_o     <= 1'b0;
      win_valid_o <= 1'b0;
    end else begin
      valid_o     <= push;
      win_valid_o <= push && (line_cnt == LINE_FULL);
      if (push) begin
        rows_o[DATA_W-1:0] <= push_data;
        for (int k = 1; k < ROWS; k++) rows_o[k*DATA_W +: DATA_W] <= rd_data[k-1];
      end
    end
  end

endmodule
